// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and the circular priority pick for the 8-way round-robin arbiter.
package arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int NUM_REQ   = 8;
  localparam int SEL_WIDTH = 3;

  // Search starts at ptr+1 and wraps, so the index at ptr itself is the lowest priority.
  function automatic logic [SEL_WIDTH:0] rr_pick(input logic [NUM_REQ-1:0]   req,
                                                  input logic [SEL_WIDTH-1:0] ptr);
    logic [NUM_REQ-1:0]   rot;
    logic [SEL_WIDTH-1:0] start;
    logic [SEL_WIDTH-1:0] off;
    logic                 found;
    start = ptr + SEL_WIDTH'(1);
    rot   = NUM_REQ'({req, req} >> start);
    found = 1'b0;
    off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = SEL_WIDTH'(i);
      end
    end
    return {found, off + start};
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_prio.sv
// Combinational rotate / priority-encode / unrotate used for every arbitration decision.
module rr_priority_encoder8
  import arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [SEL_WIDTH-1:0] ptr_i,
  output logic                 found_o,
  output logic [SEL_WIDTH-1:0] idx_o
);

  assign {found_o, idx_o} = rr_pick(req_i, ptr_i);

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the shared 8:1 mux select, with multi-beat hold and a beat limit.
module mux_rr_arbiter
  import arbiter_pkg::*;
#(
  parameter int MAX_BEATS = 16
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic [NUM_REQ-1:0]   i_Request,
  input  logic [NUM_REQ-1:0]   i_Last,
  input  logic                 i_Ready,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic [SEL_WIDTH-1:0] o_Select,
  output logic                 o_Valid,
  output logic [NUM_REQ-1:0]   o_Accept,
  output logic                 o_Timeout
);

  localparam int CNT_WIDTH = (MAX_BEATS < 1) ? 1 : $clog2(MAX_BEATS + 1);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_BEATS);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d, count_inc;
  logic                 timeout_q, timeout_d;
  logic [SEL_WIDTH-1:0] arb_ptr, win_idx;
  logic                 win_found, busy, xfer, limit_hit, release_grant;

  assign busy          = (state_q == BUSY);
  assign o_Valid       = busy & i_Request[sel_q];
  assign xfer          = o_Valid & i_Ready;
  assign o_Accept      = grant_q & {NUM_REQ{xfer}};
  assign count_inc     = count_q + CNT_WIDTH'(1);
  assign limit_hit     = (MAX_BEATS > 0) && (count_inc == MAX_CNT);
  assign release_grant = busy & (~i_Request[sel_q] | (xfer & (i_Last[sel_q] | limit_hit)));

  // Releasing index is the pointer, so it is automatically last in line on re-arbitration.
  assign arb_ptr = busy ? sel_q : ptr_q;

  rr_priority_encoder8 u_prio (
    .req_i   (i_Request),
    .ptr_i   (arb_ptr),
    .found_o (win_found),
    .idx_o   (win_idx)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = BUSY;
          grant_d = NUM_REQ'(1) << win_idx;
          sel_d   = win_idx;
          count_d = '0;
        end
      end
      BUSY: begin
        if (xfer && (MAX_BEATS == 0 || count_q != MAX_CNT)) begin
          count_d = count_inc;
        end
        if (release_grant) begin
          ptr_d     = sel_q;
          timeout_d = xfer & limit_hit & ~i_Last[sel_q];
          count_d   = '0;
          if (win_found) begin
            grant_d = NUM_REQ'(1) << win_idx;
            sel_d   = win_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      ptr_q     <= SEL_WIDTH'(NUM_REQ - 1);
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_Grant   = grant_q;
  assign o_Select  = sel_q;
  assign o_Timeout = timeout_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural arbiter model.
module tb_mux_rr_arbiter;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req, last;
  logic       rdy;
  logic [7:0] o_Grant, o_Accept;
  logic [2:0] o_Select;
  logic       o_Valid, o_Timeout;

  int checks = 0;
  int errors = 0;

  // Model: owner is the granted requester (-1 when idle).
  int m_owner, m_ptr, m_sel, m_beats;
  bit m_tmo;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.MAX_BEATS(MAXB)) dut (
    .i_Clock   (clk),
    .i_Reset   (rst_n),
    .i_Request (req),
    .i_Last    (last),
    .i_Ready   (rdy),
    .o_Grant   (o_Grant),
    .o_Select  (o_Select),
    .o_Valid   (o_Valid),
    .o_Accept  (o_Accept),
    .o_Timeout (o_Timeout)
  );

  function automatic int pick(logic [7:0] r, int from);
    for (int k = 1; k <= 8; k++) begin
      if (r[(from + k) % 8]) return (from + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 7; m_sel = 0; m_beats = 0; m_tmo = 0;
  endtask

  task automatic model_clock();
    bit rel, tmo_n;
    int w;
    rel = 0; tmo_n = 0;
    if (m_owner < 0) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin m_owner = w; m_sel = w; m_beats = 0; end
    end else begin
      if (!req[m_owner]) rel = 1;
      else if (rdy) begin
        m_beats++;
        if (last[m_owner]) rel = 1;
        else if (m_beats == MAXB) begin rel = 1; tmo_n = 1; end
      end
      if (rel) begin
        m_ptr = m_owner;
        w = pick(req, m_owner);
        if (w >= 0) begin m_owner = w; m_sel = w; m_beats = 0; end
        else m_owner = -1;
      end
    end
    m_tmo = tmo_n;
  endtask

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    logic [7:0] eg;
    logic       ev;
    eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
    ev = (m_owner >= 0) && req[m_owner];
    chk("grant",   o_Grant,             eg);
    chk("select",  {5'b0, o_Select},    8'(m_sel));
    chk("valid",   {7'b0, o_Valid},     {7'b0, ev});
    chk("accept",  o_Accept,            (ev && rdy) ? eg : 8'h00);
    chk("timeout", {7'b0, o_Timeout},   {7'b0, m_tmo});
  endtask

  task automatic drive(input logic [7:0] r, input logic [7:0] l, input logic y);
    @(negedge clk);
    req = r; last = l; rdy = y;
    #1;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
  endtask

  initial begin
    rst_n = 1'b0; req = '0; last = '0; rdy = 1'b0;
    model_reset();
    #3;
    check_model();
    @(negedge clk);
    rst_n = 1'b1;

    // reset and first grant
    drive(8'h01, 8'h01, 1'b1); tick();
    drive(8'h01, 8'h01, 1'b1);
    chk("t1_grant", o_Grant, 8'h01);
    chk("t1_valid", {7'b0, o_Valid}, 8'h01);
    chk("t1_accept", o_Accept, 8'h01);
    tick();
    drive(8'h00, 8'h00, 1'b1); tick();
    drive(8'h00, 8'h00, 1'b1);
    chk("t1_idle", o_Grant, 8'h00);
    tick();

    // multi-beat hold with a stall
    drive(8'h04, 8'h00, 1'b0); tick();
    drive(8'h24, 8'h00, 1'b1); chk("mb_b1", o_Accept, 8'h04); tick();
    drive(8'h24, 8'h00, 1'b0); chk("mb_stall", {5'b0, o_Select}, 8'd2); chk("mb_stall_acc", o_Accept, 8'h00); tick();
    drive(8'h24, 8'h00, 1'b1); chk("mb_b2", o_Accept, 8'h04); tick();
    drive(8'h24, 8'h04, 1'b1); chk("mb_b3", o_Accept, 8'h04); tick();
    drive(8'h20, 8'h00, 1'b0); chk("mb_next", {5'b0, o_Select}, 8'd5); tick();
    drive(8'h20, 8'h20, 1'b1); tick();
    drive(8'h00, 8'h00, 1'b0); tick();
    drive(8'h00, 8'h00, 1'b0); tick();

    // beat limit
    drive(8'h08, 8'h00, 1'b1); tick();
    for (int b = 0; b < MAXB; b++) begin
      drive(8'h48, 8'h00, 1'b1);
      chk("bl_acc", o_Accept, 8'h08);
      chk("bl_no_tmo", {7'b0, o_Timeout}, 8'h00);
      tick();
    end
    drive(8'h40, 8'h00, 1'b0);
    chk("bl_tmo", {7'b0, o_Timeout}, 8'h01);
    chk("bl_sel", {5'b0, o_Select}, 8'd6);
    tick();
    drive(8'h40, 8'h00, 1'b0); chk("bl_tmo_end", {7'b0, o_Timeout}, 8'h00); tick();
    drive(8'h00, 8'h00, 1'b0); tick();
    drive(8'h00, 8'h00, 1'b0); tick();

    // abort
    drive(8'h02, 8'h00, 1'b0); tick();
    drive(8'h02, 8'h00, 1'b0); chk("ab_sel", {5'b0, o_Select}, 8'd1); tick();
    drive(8'h10, 8'h00, 1'b1); chk("ab_acc", o_Accept, 8'h00); tick();
    drive(8'h10, 8'h00, 1'b0);
    chk("ab_grant", o_Grant, 8'h10);
    chk("ab_tmo", {7'b0, o_Timeout}, 8'h00);
    tick();
    drive(8'h00, 8'h00, 1'b0); tick();
    drive(8'h00, 8'h00, 1'b0); tick();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      drive(8'($urandom), 8'($urandom & $urandom), ($urandom_range(0, 3) != 0));
      tick();
    end

    // async reset while busy
    drive(8'hFF, 8'h00, 1'b0); tick();
    drive(8'hFF, 8'h00, 1'b0); tick();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_grant", o_Grant, 8'h00);
    chk("ar_valid", {7'b0, o_Valid}, 8'h00);
    req = 8'h00;
    model_reset();
    #1;
    check_model();
    @(negedge clk);
    rst_n = 1'b1;

    // round robin from reset
    drive(8'hFF, 8'hFF, 1'b1); tick();
    for (int k = 0; k < 9; k++) begin
      drive(8'hFF, 8'hFF, 1'b1);
      chk("rr_sel", {5'b0, o_Select}, 8'(k % 8));
      chk("rr_valid", {7'b0, o_Valid}, 8'h01);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
